spike_train_decoder: RTL and testbench

- Sits downstream of the Izhikevich neuron core and consumes its 8-bit membrane-voltage stream (signed Q1.6, LSB = 1/64).
- Detects spikes with hysteresis and measures inter-spike intervals (ISI) in sample beats.
- Buffers ISIs in a small FIFO drained over a valid/ready interface.
- Reports a windowed spike count, so firing behaviour (RS/IB/CH/FS/...) can be decoded on-chip or by a host.

---
 rtl/spike_train_decoder_pkg.sv | 16 +
 rtl/spike_train_decoder_isi_fifo.sv | 59 +++++
 rtl/spike_train_decoder.sv | 124 ++++++++++++
 tb/tb_spike_train_decoder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/spike_train_decoder_pkg.sv
// Types and constants shared by the spike train decoder and the Izhikevich neuron core.
package spike_train_decoder_pkg;

    // Membrane voltage format: signed Q1.6, so one LSB is 2^-Q_FRAC_BITS = 1/64.
    localparam int Q_FRAC_BITS = 6;

    localparam logic signed [7:0] THR_HI_DEF = 8'sd19;   // 0.30
    localparam logic signed [7:0] THR_LO_DEF = -8'sd20;  // -0.31

    typedef enum logic [1:0] {
        NO_REF    = 2'd0,
        ARMED     = 2'd1,
        FIRED_REF = 2'd2
    } det_state_t;

endpackage

// File: rtl/spike_train_decoder_isi_fifo.sv
// Small synchronous FIFO. A push into a full FIFO is accepted only when a pop
// happens in the same cycle; otherwise it is dropped and flagged.
module isi_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             not_empty,
    output logic             drop
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr_reg, wr_ptr_reg;
    logic [AW:0]      count_reg;
    logic             full, empty, pop_eff, push_eff;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == (AW+1)'(DEPTH));
    assign pop_eff   = pop & ~empty;
    assign push_eff  = push & (~full | pop_eff);
    assign drop      = push & full & ~pop_eff;
    assign not_empty = ~empty;
    // Stale entries stay in the array after a flush, so the head is masked when empty.
    assign head      = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_eff) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop_eff)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push_eff, pop_eff})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/spike_train_decoder.sv
// Hysteresis spike detector with inter-spike-interval FIFO and windowed spike rate,
// fed by the membrane-voltage stream of the neuron core.
module spike_train_decoder
    import spike_train_decoder_pkg::*;
#(
    parameter int W     = 8,
    parameter int ISI_W = 16,
    parameter int DEPTH = 4,
    parameter int WIN_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                sample_valid,
    input  logic signed [W-1:0] v_sample,
    input  logic signed [W-1:0] thr_hi,
    input  logic signed [W-1:0] thr_lo,
    input  logic [WIN_W-1:0]    win_len,
    output logic                spike_pulse,
    output logic [ISI_W-1:0]    isi_data,
    output logic                isi_valid,
    input  logic                isi_ready,
    output logic [WIN_W-1:0]    rate_count,
    output logic                rate_valid,
    output logic                overflow
);
    det_state_t       state_reg, state_next;
    logic             spike, emit, fifo_drop, window_close;
    logic [ISI_W-1:0] isi_cnt_reg, isi_inc;
    logic [WIN_W-1:0] win_cnt_reg, spk_cnt_reg, spk_inc, rate_count_reg;
    logic             spike_pulse_reg, rate_valid_reg, overflow_reg;

    always_comb begin
        state_next = state_reg;
        spike      = 1'b0;
        emit       = 1'b0;
        if (sample_valid) begin
            case (state_reg)
                NO_REF, ARMED: begin
                    if (v_sample > thr_hi) begin
                        spike      = 1'b1;
                        emit       = (state_reg == ARMED);
                        state_next = FIRED_REF;
                    end
                end
                FIRED_REF: begin
                    if (v_sample < thr_lo) state_next = ARMED;
                end
                default: state_next = NO_REF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     state_reg <= NO_REF;
        else if (clear) state_reg <= NO_REF;
        else            state_reg <= state_next;
    end

    // Saturating increments; the emitted ISI is the distance in samples, i.e. count+1.
    assign isi_inc = (&isi_cnt_reg) ? isi_cnt_reg : isi_cnt_reg + ISI_W'(1);
    assign spk_inc = (spike && !(&spk_cnt_reg)) ? spk_cnt_reg + WIN_W'(1) : spk_cnt_reg;
    // ">=" also closes a window that overshot after win_len was lowered mid-window.
    assign window_close = sample_valid && (win_len != '0) && (win_cnt_reg >= win_len - WIN_W'(1));

    isi_fifo #(
        .WIDTH (ISI_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .push      (emit),
        .push_data (isi_inc),
        .pop       (isi_ready),
        .head      (isi_data),
        .not_empty (isi_valid),
        .drop      (fifo_drop)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            isi_cnt_reg     <= '0;
            win_cnt_reg     <= '0;
            spk_cnt_reg     <= '0;
            rate_count_reg  <= '0;
            rate_valid_reg  <= 1'b0;
            spike_pulse_reg <= 1'b0;
            overflow_reg    <= 1'b0;
        end else if (clear) begin
            isi_cnt_reg     <= '0;
            win_cnt_reg     <= '0;
            spk_cnt_reg     <= '0;
            rate_count_reg  <= '0;
            rate_valid_reg  <= 1'b0;
            spike_pulse_reg <= 1'b0;
            overflow_reg    <= 1'b0;
        end else begin
            spike_pulse_reg <= spike;
            rate_valid_reg  <= window_close;
            overflow_reg    <= overflow_reg | fifo_drop;
            if (sample_valid) begin
                isi_cnt_reg <= spike ? '0 : isi_inc;
            end
            if (win_len == '0) begin
                win_cnt_reg <= '0;
                spk_cnt_reg <= '0;
            end else if (window_close) begin
                rate_count_reg <= spk_inc;
                win_cnt_reg    <= '0;
                spk_cnt_reg    <= '0;
            end else if (sample_valid) begin
                win_cnt_reg <= win_cnt_reg + WIN_W'(1);
                spk_cnt_reg <= spk_inc;
            end
        end
    end

    assign spike_pulse = spike_pulse_reg;
    assign rate_count  = rate_count_reg;
    assign rate_valid  = rate_valid_reg;
    assign overflow    = overflow_reg;

endmodule

// File: tb/tb_spike_train_decoder.sv
// Directed and randomized bench for spike_train_decoder against a sample-index based model.
module tb_spike_train_decoder;
    import spike_train_decoder_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              clear;
    logic              sample_valid;
    logic signed [7:0] v_sample;
    logic signed [7:0] thr_hi;
    logic signed [7:0] thr_lo;
    logic [15:0]       win_len;
    logic              spike_pulse;
    logic [15:0]       isi_data;
    logic              isi_valid;
    logic              isi_ready;
    logic [15:0]       rate_count;
    logic              rate_valid;
    logic              overflow;

    spike_train_decoder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .sample_valid (sample_valid),
        .v_sample     (v_sample),
        .thr_hi       (thr_hi),
        .thr_lo       (thr_lo),
        .win_len      (win_len),
        .spike_pulse  (spike_pulse),
        .isi_data     (isi_data),
        .isi_valid    (isi_valid),
        .isi_ready    (isi_ready),
        .rate_count   (rate_count),
        .rate_valid   (rate_valid),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: spikes are tracked by sample index, the FIFO is a queue.
    int idx;
    int last_spike_idx;
    bit have_prev;
    bit armed;
    int q[$];
    bit m_ovf;
    int win_n;
    int win_spk;
    int m_rate;
    bit e_spike;
    bit e_rate_valid;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        idx = 0; last_spike_idx = 0; have_prev = 0; armed = 1;
        q.delete(); m_ovf = 0; win_n = 0; win_spk = 0; m_rate = 0;
        e_spike = 0; e_rate_valid = 0;
    endtask

    // Predicts the effect of the coming clock edge from the inputs now applied.
    task automatic model_edge();
        int vs, isi;
        bit spk;
        if (clear) begin
            model_reset();
            return;
        end
        e_spike = 0; e_rate_valid = 0; spk = 0;
        if (isi_ready && q.size() > 0) void'(q.pop_front());
        if (sample_valid) begin
            idx++;
            vs = int'(v_sample);
            if (armed && vs > int'(thr_hi)) begin
                spk = 1; e_spike = 1; armed = 0;
                if (have_prev) begin
                    isi = idx - last_spike_idx;
                    if (isi > 65535) isi = 65535;
                    if (q.size() < 4) q.push_back(isi);
                    else m_ovf = 1;
                end
                have_prev = 1;
                last_spike_idx = idx;
            end else if (!armed && vs < int'(thr_lo)) begin
                armed = 1;
            end
            if (win_len != 0) begin
                win_n++;
                if (spk && win_spk < 65535) win_spk++;
                if (win_n >= int'(win_len)) begin
                    m_rate = win_spk; e_rate_valid = 1; win_n = 0; win_spk = 0;
                end
            end
        end
        if (win_len == 0) begin
            win_n = 0; win_spk = 0;
        end
    endtask

    task automatic check_outputs(input string ph);
        check({ph, ".spike_pulse"}, spike_pulse, e_spike);
        check({ph, ".isi_valid"}, isi_valid, (q.size() > 0));
        check({ph, ".isi_data"}, isi_data, (q.size() > 0) ? q[0] : 0);
        check({ph, ".overflow"}, overflow, m_ovf);
        check({ph, ".rate_valid"}, rate_valid, e_rate_valid);
        check({ph, ".rate_count"}, rate_count, m_rate);
    endtask

    task automatic step(input string ph, input bit vld, input int v, input bit rdy);
        sample_valid = vld;
        v_sample     = 8'(v);
        isi_ready    = rdy;
        model_edge();
        @(posedge clk);
        #1;
        check_outputs(ph);
    endtask

    task automatic do_clear();
        clear = 1;
        step("clear", 0, 0, 0);
        clear = 0;
    endtask

    int basic_s[8] = '{-45, -30, 25, -45, -40, -38, 30, -45};
    int hyst_s[8]  = '{-45, 25, 10, 25, -10, 25, -30, 25};

    initial begin
        rst_n = 0; clear = 0; sample_valid = 0; v_sample = 0; isi_ready = 0;
        thr_hi = THR_HI_DEF; thr_lo = THR_LO_DEF; win_len = 0;
        model_reset();
        #12;
        rst_n = 1;
        check_outputs("reset");

        foreach (basic_s[i]) step("basic", 1, basic_s[i], 0);
        check("basic.isi_value", isi_data, 4);

        do_clear();
        foreach (hyst_s[i]) step("hyst", 1, hyst_s[i], 0);
        check("hyst.isi_value", isi_data, 6);

        // Six spikes with growing gaps while the consumer stalls.
        do_clear();
        for (int k = 0; k < 6; k++) begin
            step("ovf", 1, 30, 0);
            for (int j = 0; j <= k; j++) step("ovf", 1, -45, 0);
        end
        check("ovf.sticky", overflow, 1);
        for (int k = 0; k < 5; k++) step("drain", 1, 0, 1);

        // Full FIFO accepts a new ISI when it is popped in the same cycle.
        do_clear();
        for (int k = 0; k < 5; k++) begin
            step("full", 1, 30, 0);
            step("full", 1, -45, 0);
        end
        step("fullpp", 1, 30, 1);
        check("fullpp.no_overflow", overflow, 0);
        for (int k = 0; k < 5; k++) step("drain2", 1, 0, 1);

        do_clear();
        win_len = 10;
        for (int i = 0; i < 40; i++) step("rate", 1, (i % 4 == 0) ? 30 : -45, 1);
        check("rate.last_count", rate_count, 2);
        win_len = 0;
        for (int i = 0; i < 12; i++) step("rate0", 1, (i % 4 == 0) ? 30 : -45, 1);

        // Asynchronous reset between clock edges while an ISI is pending.
        do_clear();
        step("prerst", 1, 30, 0); step("prerst", 1, -45, 0); step("prerst", 1, 30, 0);
        check("prerst.isi_valid", isi_valid, 1);
        #2;
        rst_n = 0;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(posedge clk);
        #1;
        check_outputs("rst_hold");
        rst_n = 1;
        step("postrst", 1, 30, 0); step("postrst", 1, -45, 0);
        check("postrst.no_isi", isi_valid, 0);
        step("postrst", 1, 30, 0);

        // Same sequence with the soft clear.
        do_clear();
        step("preclr", 1, 30, 0); step("preclr", 1, -45, 0); step("preclr", 1, 30, 0);
        do_clear();
        step("postclr", 1, 30, 0); step("postclr", 1, -45, 0);
        check("postclr.no_isi", isi_valid, 0);
        step("postclr", 1, 30, 0);

        do_clear();
        win_len = 5;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_clear();
            end else begin
                if ($urandom_range(0, 99) == 0) win_len = 16'($urandom_range(0, 8));
                if ($urandom_range(0, 149) == 0) begin
                    thr_hi = 8'($urandom_range(0, 60));
                    thr_lo = 8'(int'(thr_hi) - int'($urandom_range(1, 60)));
                end
                step("rand", ($urandom_range(0, 3) != 0), int'($urandom_range(0, 255)) - 128,
                     $urandom_range(0, 2) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
